// File: rtl/im_loader.sv
// rtl/im_loader.sv - boot-stream loader that fills instruction memory and releases the CPU.
// Optional trailing XOR checksum byte enabled by macro IM_LOADER_CHECKSUM_EN.
module im_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        im_we,
    output logic [9:0]  im_addr,
    output logic [31:0] im_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        HDR_HI,
        HDR_LO,
        DATA,
`ifdef IM_LOADER_CHECKSUM_EN
        CSUM,
`endif
        DONE,
        ERR
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  hdr_hi_q;
    logic [10:0] n_words_q;
    logic [1:0]  byte_cnt_q;
    logic [10:0] word_idx_q;
    logic [23:0] shift_q;
    logic        im_we_q;
    logic [9:0]  im_addr_q;
    logic [31:0] im_wdata_q;
`ifdef IM_LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    logic        accept;
    logic [15:0] hdr_n;
    logic        word_end;
    logic        last_word;

    assign accept    = in_valid && in_ready;
    assign hdr_n     = {hdr_hi_q, in_data};
    assign word_end  = accept && (state_q == DATA) && (byte_cnt_q == 2'd3);
    // word_idx_q is 11 bits so the compare against N=1024 never aliases
    assign last_word = word_end && ((word_idx_q + 11'd1) == n_words_q);

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        cpu_hold = 1'b1;
        done     = 1'b0;
        err      = 1'b0;
        case (state_q)
            HDR_HI: begin
                in_ready = 1'b1;
                if (accept) state_d = HDR_LO;
            end
            HDR_LO: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (hdr_n == 16'd0 || hdr_n > 16'd1024) state_d = ERR;
                    else                                    state_d = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
`ifdef IM_LOADER_CHECKSUM_EN
                if (last_word) state_d = CSUM;
`else
                if (last_word) state_d = DONE;
`endif
            end
`ifdef IM_LOADER_CHECKSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                if (accept) state_d = (in_data == csum_q) ? DONE : ERR;
            end
`endif
            DONE: begin
                cpu_hold = 1'b0;
                done     = 1'b1;
            end
            ERR: begin
                err = 1'b1;
            end
            default: state_d = ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= HDR_HI;
            hdr_hi_q   <= 8'd0;
            n_words_q  <= 11'd0;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 11'd0;
            shift_q    <= 24'd0;
            im_we_q    <= 1'b0;
            im_addr_q  <= 10'd0;
            im_wdata_q <= 32'd0;
`ifdef IM_LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            im_we_q <= 1'b0;
            if (accept && state_q == HDR_HI) hdr_hi_q <= in_data;
            if (accept && state_q == HDR_LO) n_words_q <= hdr_n[10:0];
            if (accept && state_q == DATA) begin
                byte_cnt_q <= byte_cnt_q + 2'd1;
                shift_q    <= {shift_q[15:0], in_data};
`ifdef IM_LOADER_CHECKSUM_EN
                csum_q     <= csum_q ^ in_data;
`endif
            end
            if (word_end) begin
                im_we_q    <= 1'b1;
                im_addr_q  <= word_idx_q[9:0];
                im_wdata_q <= {shift_q, in_data};
                word_idx_q <= word_idx_q + 11'd1;
            end
        end
    end

    assign im_we    = im_we_q;
    assign im_addr  = im_addr_q;
    assign im_wdata = im_wdata_q;

endmodule
